// File: rtl/gon_bus.sv
// gon_bus: gather bus for the global output network.
// Collects partial sums from PE_NUMS sources on one row and forwards them,
// one per cycle, to a single upstream consumer. Sources are picked
// round-robin. Each beat carries the winning source index and that
// source's destination ID, which is loaded through a scan chain.
// A beat counter pulses done when a configured number of beats has drained.
module gon_bus #(
  parameter int PE_NUMS   = 14,
  parameter int ID_LEN    = 5,
  parameter int VALUE_LEN = 32,
  parameter int SRC_LEN   = 4,
  parameter int CNT_LEN   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PE_NUMS-1:0]             pe_valid,
  input  logic [PE_NUMS*VALUE_LEN-1:0]   pe_data,
  output logic [PE_NUMS-1:0]             pe_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [VALUE_LEN-1:0]           out_data,
  output logic [ID_LEN-1:0]              out_id,
  output logic [SRC_LEN-1:0]             out_src,
  input  logic [CNT_LEN-1:0]             expect_cnt,
  output logic                           done,
  input  logic                           set_id,
  input  logic [ID_LEN-1:0]              id_scan_in,
  output logic [ID_LEN-1:0]              id_scan_out
);

  logic [ID_LEN-1:0]    id_reg [PE_NUMS];
  logic [SRC_LEN-1:0]   rr_ptr;
  logic [CNT_LEN-1:0]   beat_cnt;

  logic [SRC_LEN-1:0]   grant_idx;
  logic [SRC_LEN-1:0]   cand;
  logic [SRC_LEN:0]     cand_sum;
  logic                 grant_found;
  logic                 can_load;
  logic                 grant_allow;
  logic                 transfer;
  logic                 out_fire;
  logic [VALUE_LEN-1:0] grant_data;

  // The output register may take a new beat when it is empty or draining
  // this cycle; grants are blocked while the ID chain shifts or in reset.
  assign can_load    = !out_valid || out_ready;
  assign grant_allow = can_load && !set_id && !rst;
  assign transfer    = grant_allow && grant_found;
  assign out_fire    = out_valid && out_ready;
  assign grant_data  = pe_data[grant_idx*VALUE_LEN +: VALUE_LEN];
  assign id_scan_out = id_reg[PE_NUMS-1];

  // Round-robin search: first valid source starting at rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_sum    = '0;
    for (int k = 0; k < PE_NUMS; k++) begin
      cand_sum = {1'b0, rr_ptr} + (SRC_LEN+1)'(k);
      if (cand_sum >= (SRC_LEN+1)'(PE_NUMS)) begin
        cand_sum = cand_sum - (SRC_LEN+1)'(PE_NUMS);
      end
      cand = cand_sum[SRC_LEN-1:0];
      if (!grant_found && pe_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Only the winning source sees ready, and only when the beat can be taken.
  always_comb begin
    pe_ready = '0;
    if (transfer) begin
      pe_ready[grant_idx] = 1'b1;
    end
  end

  // ID scan chain: shifts toward the last source, which feeds the next bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PE_NUMS; i++) begin
        id_reg[i] <= '0;
      end
    end else if (set_id) begin
      id_reg[0] <= id_scan_in;
      for (int i = 1; i < PE_NUMS; i++) begin
        id_reg[i] <= id_reg[i-1];
      end
    end
  end

  // Output beat register and round-robin pointer; a load overrides a drain
  // so back-to-back beats flow without bubbles, and everything holds under
  // backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_id    <= id_reg[grant_idx];
      out_src   <= grant_idx;
      rr_ptr    <= (grant_idx == SRC_LEN'(PE_NUMS-1)) ? '0 : grant_idx + 1'b1;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // Beat counter: pulses done one cycle after the last output handshake of
  // a pass; a zero expect_cnt freezes the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      done     <= 1'b0;
    end else if (out_fire && (expect_cnt != '0)) begin
      if (beat_cnt == expect_cnt - 1'b1) begin
        beat_cnt <= '0;
        done     <= 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        done     <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gon_bus.sv
// tb_gon_bus: directed bench for gon_bus with a scoreboard of expected
// output beats consumed by an independent monitor process.
module tb_gon_bus;

  localparam int PE_NUMS   = 14;
  localparam int ID_LEN    = 5;
  localparam int VALUE_LEN = 32;
  localparam int SRC_LEN   = 4;
  localparam int CNT_LEN   = 16;

  typedef struct packed {
    logic [VALUE_LEN-1:0] data;
    logic [ID_LEN-1:0]    id;
    logic [SRC_LEN-1:0]   src;
  } beat_t;

  logic                          clk;
  logic                          rst;
  logic [PE_NUMS-1:0]            pe_valid;
  logic [PE_NUMS*VALUE_LEN-1:0]  pe_data;
  logic [PE_NUMS-1:0]            pe_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic [VALUE_LEN-1:0]          out_data;
  logic [ID_LEN-1:0]             out_id;
  logic [SRC_LEN-1:0]            out_src;
  logic [CNT_LEN-1:0]            expect_cnt;
  logic                          done;
  logic                          set_id;
  logic [ID_LEN-1:0]             id_scan_in;
  logic [ID_LEN-1:0]             id_scan_out;

  logic [VALUE_LEN-1:0] slot [PE_NUMS];
  beat_t                sb [$];
  int                   checks;
  int                   errors;
  logic                 ids_loaded;

  gon_bus #(
    .PE_NUMS(PE_NUMS), .ID_LEN(ID_LEN), .VALUE_LEN(VALUE_LEN),
    .SRC_LEN(SRC_LEN), .CNT_LEN(CNT_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .pe_valid(pe_valid), .pe_data(pe_data), .pe_ready(pe_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_src(out_src),
    .expect_cnt(expect_cnt), .done(done),
    .set_id(set_id), .id_scan_in(id_scan_in), .id_scan_out(id_scan_out)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Flatten per-source data slots onto the packed data bus.
  always_comb begin
    pe_data = '0;
    for (int i = 0; i < PE_NUMS; i++) begin
      pe_data[i*VALUE_LEN +: VALUE_LEN] = slot[i];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: drive sources, check grant and done, queue the expected
  // beat for the granted source, then advance to just past the next edge.
  task automatic applyStimulus(input logic [PE_NUMS-1:0] valid, input logic rdy,
                               input logic [PE_NUMS-1:0] exp_ready, input logic exp_done);
    beat_t b;
    pe_valid  = valid;
    out_ready = rdy;
    #1;
    checkOutput("pe_ready", 64'(pe_ready), 64'(exp_ready));
    checkOutput("done", 64'(done), 64'(exp_done));
    for (int i = 0; i < PE_NUMS; i++) begin
      if (exp_ready[i]) begin
        b.data = slot[i];
        b.id   = ids_loaded ? ID_LEN'(i) : '0;
        b.src  = SRC_LEN'(i);
        sb.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: on every output handshake, pop the oldest expected beat.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat got src %0d expected no beat", out_src);
        end else begin
          b = sb.pop_front();
          checkOutput("out_data", 64'(out_data), 64'(b.data));
          checkOutput("out_id", 64'(out_id), 64'(b.id));
          checkOutput("out_src", 64'(out_src), 64'(b.src));
        end
      end
    end
  end

  initial begin
    logic [PE_NUMS-1:0] one_hot;
    checks     = 0;
    errors     = 0;
    ids_loaded = 1'b0;
    for (int i = 0; i < PE_NUMS; i++) begin
      slot[i] = 32'hA5A5_0000 | (32'(i) * 32'h0101);
    end
    rst        = 1'b1;
    pe_valid   = '1;
    out_ready  = 1'b1;
    expect_cnt = '0;
    set_id     = 1'b0;
    id_scan_in = '0;

    // Reset state, with every source requesting.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_pe_ready", 64'(pe_ready), 64'd0);
    checkOutput("rst_scan_out", 64'(id_scan_out), 64'd0);
    rst = 1'b0;

    // Scan in IDs 13..0 so that id_reg[i] = i; no grants while shifting.
    for (int j = 0; j < PE_NUMS; j++) begin
      set_id     = 1'b1;
      id_scan_in = ID_LEN'(PE_NUMS - 1 - j);
      #1;
      checkOutput("scan_pe_ready", 64'(pe_ready), 64'd0);
      if (j == 0) checkOutput("scan_out_first", 64'(id_scan_out), 64'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("scan_out_last", 64'(id_scan_out), 64'd13);
    checkOutput("scan_out_valid", 64'(out_valid), 64'd0);
    set_id     = 1'b0;
    pe_valid   = '0;
    ids_loaded = 1'b1;

    // Single source 2, then sources 1 and 4 show rr_ptr moved to 3.
    slot[2] = 32'hDEADBEEF;
    applyStimulus(14'h0004, 1'b1, 14'h0004, 1'b0);
    applyStimulus(14'h0012, 1'b1, 14'h0010, 1'b0);

    // Park rr_ptr at 0 via source 13, then all sources valid back to back.
    applyStimulus(14'h2000, 1'b1, 14'h2000, 1'b0);
    for (int k = 0; k <= PE_NUMS; k++) begin
      one_hot = 14'd1 << (k % PE_NUMS);
      applyStimulus('1, 1'b1, one_hot, 1'b0);
    end
    applyStimulus('0, 1'b1, '0, 1'b0);

    // Backpressure: source 5 held for 3 stalled cycles, then source 9 wins.
    applyStimulus(14'h0220, 1'b1, 14'h0020, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_out_src", 64'(out_src), 64'd5);
      applyStimulus(14'h0220, 1'b0, '0, 1'b0);
    end
    applyStimulus(14'h0220, 1'b1, 14'h0200, 1'b0);
    applyStimulus('0, 1'b1, '0, 1'b0);

    // Done pulse: six beats then two more with expect_cnt = 4.
    expect_cnt = 16'd4;
    for (int c = 1; c <= 13; c++) begin
      applyStimulus((c <= 6 || c == 9 || c == 10) ? 14'h0008 : 14'h0000, 1'b1,
                    (c <= 6 || c == 9 || c == 10) ? 14'h0008 : 14'h0000,
                    (c == 6 || c == 12));
    end
    expect_cnt = '0;

    // Reset with a stalled beat pending.
    applyStimulus(14'h0080, 1'b0, 14'h0080, 1'b0);
    applyStimulus('0, 1'b0, '0, 1'b0);
    checkOutput("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst       = 1'b1;
    pe_valid  = '1;
    out_ready = 1'b1;
    #1;
    checkOutput("rst_mid_pe_ready", 64'(pe_ready), 64'd0);
    checkOutput("rst_pending_beats", 64'(sb.size()), 64'd1);
    sb.delete();
    ids_loaded = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid_scan_out", 64'(id_scan_out), 64'd0);
    rst = 1'b0;
    applyStimulus(14'h0201, 1'b1, 14'h0001, 1'b0);
    applyStimulus(14'h0201, 1'b1, 14'h0200, 1'b0);
    applyStimulus('0, 1'b1, '0, 1'b0);
    applyStimulus('0, 1'b1, '0, 1'b0);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
